t_mem_loader: RTL and testbench
===============================

# t_mem_loader

Writer side of the modular-exponentiation operand memories: it accepts a narrow chunk stream over a valid/ready handshake and packs the chunks into `DATA_WIDTH` words. It writes those words sequentially from address 0 into a single-port synchronous RAM, the same geometry as the read-only `t` store. It sits between the host/UART front end and the operand RAM, and it populates the RAM before the exponentiation engine starts reading.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: RAM word width.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: RAM address width.
- `TOTAL_ADDR`, default `` `TOTAL_ADDR ``: number of words per load, 1..2^ADDR_WIDTH.
- `IN_WIDTH`, default 8: chunk width. `DATA_WIDTH % IN_WIDTH == 0`. CHUNKS = DATA_WIDTH/IN_WIDTH.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: begins a load at address 0. Accepted only in IDLE or DONE.
- `in_valid`, in, 1: chunk valid.
- `in_data`, in, IN_WIDTH: chunk.
- `in_ready`, out, 1: chunk accepted when `in_valid & in_ready`.
- `mem_address`, out, ADDR_WIDTH: RAM address.
- `mem_data`, out, DATA_WIDTH: RAM write data.
- `mem_wren`, out, 1: RAM write enable.
- `mem_q`, in, DATA_WIDTH: RAM read data. Used only with `T_MEM_VERIFY_EN`.
- `busy`, out, 1: load or verify in progress.
- `done`, out, 1: load complete. Held until the next accepted `start` or `reset`.
- `error`, out, 1: readback checksum mismatch. Held with `done`. Constant 0 without verify.

## Operation
- States: IDLE, COLLECT, WRITE, VERIFY (only with `T_MEM_VERIFY_EN`), DONE.
- IDLE/DONE → COLLECT on `start`. This transition clears word index, chunk count, `done`, `error` and the checksum.
- COLLECT:
  - `in_ready`=1.
  - Each accepted chunk k (0..CHUNKS-1) is placed in bits [k*IN_WIDTH +: IN_WIDTH], so the first chunk is least significant.
  - Address 0 holds the least-significant operand word.
  - On acceptance of chunk CHUNKS-1 → WRITE.
- WRITE:
  - Exactly one cycle. `mem_wren`=1, `mem_address`=word index, `mem_data`=packed word, `in_ready`=0.
  - The word index increments, modulo-free: it stops at TOTAL_ADDR.
  - If this was word TOTAL_ADDR-1 → VERIFY if compiled in, otherwise DONE. Else → COLLECT.
- `in_valid` outside COLLECT is ignored and no chunk is consumed.
- `start` while `busy` is ignored.
- `mem_wren` is asserted only in WRITE.
- Outputs at reset: state IDLE. `in_ready`, `mem_wren`, `busy`, `done`, `error` = 0. `mem_address`, `mem_data` = 0.
- Reset mid-load: immediate return to IDLE. RAM contents are partial and undefined. No resume.

## Timing
- Throughput: CHUNKS+1 cycles per word at full `in_valid`. TOTAL_ADDR*(CHUNKS+1) cycles per load.
- WRITE begins the cycle after the last chunk handshake.
- Without verify, `done` rises the cycle after the final WRITE and `busy` falls the same cycle.
- RAM read latency is 2 cycles: registered address, then registered output. `mem_q` for an address presented in cycle n is sampled in cycle n+2.
- VERIFY:
  - Addresses 0..TOTAL_ADDR-1 are issued one per cycle.
  - Returns are XOR-accumulated for TOTAL_ADDR+2 cycles.
- `done` rises the cycle after the last return is accumulated.

## Configuration
- `T_MEM_VERIFY_EN` defined:
  - During WRITE, the written word is XOR-accumulated into a write checksum.
  - After the final WRITE, the VERIFY sweep computes a read checksum.
  - `error`=1 at DONE if the checksums differ.
  - Load latency grows by TOTAL_ADDR+2 cycles.
- `T_MEM_VERIFY_EN` undefined:
  - No VERIFY state, no checksum registers.
  - `mem_q` is unused and `error` is tied 0.

## Structure
- Shared package `t_mem_pkg`: state encoding constants, CHUNKS derivation, and the RAM read-latency constant (2).
- Natural sub-module `t_mem_word_pack`: chunk shift/placement register with chunk counter and word-complete flag.
- The FSM, address counter and checksum logic stay in `t_mem_loader`.

## Test plan
All scenarios use the bench configuration IN_WIDTH=8, DATA_WIDTH=32, TOTAL_ADDR=4 with the behavioural RAM model.

- Full load, no stalls: `start`, then chunks 0x01..0x10 → writes 0x04030201@0, 0x08070605@1, 0x0C0B0A09@2, 0x100F0E0D@3; `done` at cycle 21 after `start`.
- Backpressure/gaps: `in_valid` toggled 1/0 → same RAM contents; `mem_wren` only in WRITE cycles; no chunk lost or duplicated.
- `start` while busy, after 6 chunks → ignored; load completes with the original data.
- Reset mid-load, after word 1 written → all outputs 0 next cycle; new `start` reloads from address 0 correctly.
- Verify path (`T_MEM_VERIFY_EN`): clean load → `error`=0. Model corrupts address 2 to 0xDEADBEEF after write → `error`=1 and `done`=1 at cycle 27.
- Restart from DONE: `start` → `done`/`error` clear in the next cycle; a second load overwrites all 4 words.

Source files
------------

// File: rtl/t_mem_pkg.sv
// Shared definitions for the t_mem operand loader: state encoding, chunk count and RAM read latency.
// Supplies fallback values for the DATA_WIDTH / ADDR_WIDTH / TOTAL_ADDR macros.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 16
`endif

package t_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int unsigned RD_LATENCY = 2;

  function automatic int unsigned chunks_of(input int unsigned data_w, input int unsigned in_w);
    return data_w / in_w;
  endfunction

endpackage

// File: rtl/t_mem_word_pack.sv
// Chunk packer: places chunk k at bits [k*IN_WIDTH +: IN_WIDTH] and flags the final chunk of a word.
module t_mem_word_pack
  import t_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IN_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [IN_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_last_c
);

  localparam int unsigned CHUNKS = chunks_of(DATA_WIDTH, IN_WIDTH);
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  w_at_last;

  assign w_at_last = (r_cnt == CW'(CHUNKS - 1));
  assign o_last_c  = i_valid & w_at_last;
  assign o_word    = r_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_valid) begin
      for (int k = 0; k < int'(CHUNKS); k++) begin
        if (r_cnt == CW'(k)) r_word[k*IN_WIDTH +: IN_WIDTH] <= i_data;
      end
      r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/t_mem_loader.sv
// Operand RAM loader: packs a chunk stream into words and writes them from address 0 upward.
// Optional readback checksum sweep enabled by defining T_MEM_VERIFY_EN.
module t_mem_loader
  import t_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned TOTAL_ADDR = `TOTAL_ADDR,
  parameter int unsigned IN_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned IDXW = $clog2(TOTAL_ADDR + 1);

  state_t                r_state, w_next_state;
  logic [IDXW-1:0]       r_word_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_in_ready, r_wren, r_busy, r_done;
  logic                  w_in_ready_d, w_wren_d, w_busy_d, w_done_d;
  logic                  w_start_acc, w_accept, w_word_last, w_last_word;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_start_acc = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_accept    = in_valid & r_in_ready;
  assign w_last_word = (r_word_idx == IDXW'(TOTAL_ADDR - 1));

  t_mem_word_pack #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (IN_WIDTH)
  ) u_pack (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_start_acc),
    .i_valid  (w_accept),
    .i_data   (in_data),
    .o_word   (w_word),
    .o_last_c (w_word_last)
  );

`ifdef T_MEM_VERIFY_EN
  localparam int unsigned VW = $clog2(TOTAL_ADDR + 2);
  logic [VW-1:0]         r_vcnt;
  logic [DATA_WIDTH-1:0] r_wr_sum, r_rd_sum;
  logic                  r_error;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next_state = ST_COLLECT;
      ST_COLLECT:       if (w_word_last) w_next_state = ST_WRITE;
      ST_WRITE: begin
        if (!w_last_word)   w_next_state = ST_COLLECT;
`ifdef T_MEM_VERIFY_EN
        else                w_next_state = ST_VERIFY;
`else
        else                w_next_state = ST_DONE;
`endif
      end
`ifdef T_MEM_VERIFY_EN
      ST_VERIFY: if (r_vcnt == VW'(TOTAL_ADDR + 1)) w_next_state = ST_DONE;
`endif
      default:          w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they are registered yet aligned with the state
  always_comb begin
    w_in_ready_d = 1'b0;
    w_wren_d     = 1'b0;
    w_busy_d     = 1'b0;
    w_done_d     = 1'b0;
    case (w_next_state)
      ST_COLLECT: begin w_in_ready_d = 1'b1; w_busy_d = 1'b1; end
      ST_WRITE:   begin w_wren_d     = 1'b1; w_busy_d = 1'b1; end
      ST_VERIFY:  w_busy_d = 1'b1;
      ST_DONE:    w_done_d = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_ready <= 1'b0;
      r_wren     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_d;
      r_wren     <= w_wren_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
    end
  end

  // Word index saturates at TOTAL_ADDR; address register also drives the verify sweep
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word_idx <= '0;
      r_addr     <= '0;
    end else if (w_start_acc) begin
      r_word_idx <= '0;
      r_addr     <= '0;
    end else if (r_state == ST_WRITE) begin
      r_word_idx <= r_word_idx + IDXW'(1);
      r_addr     <= w_last_word ? '0 : ADDR_WIDTH'(r_word_idx + IDXW'(1));
    end
`ifdef T_MEM_VERIFY_EN
    else if (r_state == ST_VERIFY) begin
      r_addr <= ADDR_WIDTH'(r_vcnt + VW'(1));
    end
`endif
  end

`ifdef T_MEM_VERIFY_EN
  // Returns lag the issued address by RD_LATENCY cycles; the final compare folds in the last return
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vcnt   <= '0;
      r_wr_sum <= '0;
      r_rd_sum <= '0;
      r_error  <= 1'b0;
    end else if (w_start_acc) begin
      r_vcnt   <= '0;
      r_wr_sum <= '0;
      r_rd_sum <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == ST_WRITE) r_wr_sum <= r_wr_sum ^ w_word;
      if (r_state == ST_VERIFY) begin
        r_vcnt <= r_vcnt + VW'(1);
        if (r_vcnt >= VW'(RD_LATENCY)) begin
          r_rd_sum <= r_rd_sum ^ mem_q;
          if (r_vcnt == VW'(TOTAL_ADDR + 1)) r_error <= ((r_rd_sum ^ mem_q) != r_wr_sum);
        end
      end
    end
  end

  assign error = r_error;
`else
  logic w_unused_mem_q;
  assign w_unused_mem_q = ^mem_q;
  assign error          = 1'b0;
`endif

  assign in_ready    = r_in_ready;
  assign mem_wren    = r_wren;
  assign busy        = r_busy;
  assign done        = r_done;
  assign mem_address = r_addr;
  assign mem_data    = w_word;

endmodule

// File: tb/tb_t_mem_loader.sv
// Scoreboard bench for t_mem_loader with a 2-cycle-latency RAM model; honours T_MEM_VERIFY_EN.
module tb_t_mem_loader;

  localparam int unsigned IW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;
  localparam int unsigned TA = 4;
  localparam int unsigned CH = DW / IW;
`ifdef T_MEM_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  localparam int LAT = int'(TA * (CH + 1)) + 1 + (VFY ? int'(TA) + 2 : 0);

  logic          clk, reset, start, in_valid, in_ready, mem_wren, busy, done, error;
  logic [IW-1:0] in_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;

  t_mem_loader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TOTAL_ADDR (TA),
    .IN_WIDTH   (IW)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM: registered address, then registered data
  logic [DW-1:0] ram [TA];
  logic [AW-1:0] ra_q;
  bit            corrupt;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    ra_q  <= mem_address;
    mem_q <= (corrupt && ra_q == AW'(2)) ? 32'hDEADBEEF : ram[ra_q];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] model_mem [TA];
  logic [IW-1:0] tab [TA*CH];
  int            exp_lat, t0;
  bit            exp_err;
  int            rst_req = 0, rs_req = 0, ram_req = 0, tmo_req = 0;

  int  checks = 0, errors = 0;
  int  rst_seen = 0, rs_seen = 0, ram_seen = 0, tmo_seen = 0;
  bit  done_q = 1'b0;
  wr_t e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, away from the active edge
  always @(negedge clk) begin
    if (tmo_req != tmo_seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: handshake or done not seen within bound (cycle %0d)", cyc);
      tmo_seen = tmo_req;
    end
    if (reset) begin
      if (rst_req != rst_seen) begin
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mem_wren", 64'(mem_wren), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_mem_address", 64'(mem_address), 64'(0));
        chk("rst_mem_data", 64'(mem_data), 64'(0));
        chk("rst_no_pending_writes", 64'(exp_q.size()), 64'(0));
        rst_seen = rst_req;
      end
      done_q = 1'b0;
    end else begin
      if (mem_wren) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected (cycle %0d)",
                   mem_address, mem_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_address), 64'(e.a));
          chk("wr_data", 64'(mem_data), 64'(e.d));
          chk("wr_in_ready_low", 64'(in_ready), 64'(0));
          chk("wr_busy", 64'(busy), 64'(1));
        end
      end
      if (done && !done_q) begin
        if (exp_lat != 0) chk("done_latency", 64'(cyc - t0), 64'(exp_lat));
        chk("error_at_done", 64'(error), 64'(exp_err));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("writes_outstanding", 64'(exp_q.size()), 64'(0));
      end
      done_q = done;
      if (rs_req != rs_seen) begin
        chk("start_clears_done", 64'(done), 64'(0));
        chk("start_clears_error", 64'(error), 64'(0));
        chk("start_sets_busy", 64'(busy), 64'(1));
        rs_seen = rs_req;
      end
      if (ram_req != ram_seen) begin
        for (int i = 0; i < int'(TA); i++) chk($sformatf("ram_word%0d", i), 64'(ram[i]), 64'(model_mem[i]));
        ram_seen = ram_req;
      end
    end
  end

  task automatic send_chunk(input logic [IW-1:0] d);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!got && n < 100) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) tmo_req++;
    in_valid = 1'b0;
    in_data  = IW'($urandom);
  endtask

  task automatic run_load(input int gap_max, input int busy_at, input int abort_at,
                          input bit lat_en, input bit corr);
    logic [DW-1:0] w;
    int            n;
    corrupt = corr;
    exp_err = corr & VFY;
    exp_lat = lat_en ? LAT : 0;
    // Stray valid while idle/done must not be consumed
    in_valid = 1'b1;
    in_data  = IW'($urandom);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b1;
    t0       = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs_req++;
    for (int wi = 0; wi < int'(TA); wi++) begin
      if (wi == abort_at) begin
        @(posedge clk);
        #1;
        reset = 1'b1;
        rst_req++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      w = '0;
      for (int k = 0; k < int'(CH); k++) w[k*IW +: IW] = tab[wi*int'(CH) + k];
      model_mem[wi] = w;
      e.a = AW'(wi);
      e.d = w;
      exp_q.push_back(e);
      for (int k = 0; k < int'(CH); k++) begin
        send_chunk(tab[wi*int'(CH) + k]);
        if (wi*int'(CH) + k + 1 == busy_at) begin
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
        end
        if (gap_max > 0) begin
          repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) tmo_req++;
    ram_req++;
    @(negedge clk);
    corrupt = 1'b0;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < int'(TA*CH); i++) tab[i] = IW'(i + 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < int'(TA*CH); i++) tab[i] = IW'($urandom);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    corrupt  = 1'b0;
    exp_lat  = 0;
    exp_err  = 1'b0;
    t0       = 0;
    @(posedge clk);
    #1;
    rst_req++;
    @(posedge clk);
    #1;
    reset = 1'b0;

    fill_seq();  run_load(0, 0, int'(TA), 1'b1, 1'b0);
    fill_rand(); run_load(2, 0, int'(TA), 1'b0, 1'b0);
    fill_rand(); run_load(0, 6, int'(TA), 1'b0, 1'b0);
    fill_rand(); run_load(0, 0, 2, 1'b0, 1'b0);
    fill_rand(); run_load(0, 0, int'(TA), 1'b1, 1'b0);
    fill_seq();  run_load(0, 0, int'(TA), 1'b1, 1'b1);
    fill_rand(); run_load(1, 0, int'(TA), 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
